// File: rtl/bttn_pkg.sv
// Shared definitions for the bttn datapath: FSM encoding and counter sizing.
package bttn_pkg;

  // Control states of the bit-serial arithmetic stages.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } stateT;

  // Width of a counter that indexes bits 0..width-1 of an operand.
  function automatic int cntWidth(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fulladdition.sv
// 1-bit full adder cell, the additive twin of the fullsubtraction cell.
module fulladdition (
  input  logic A,
  input  logic B,
  input  logic CarryIN,
  output logic Sum,
  output logic CarryOut
);

  logic halfSum;

  assign halfSum  = A ^ B;
  assign Sum      = halfSum ^ CarryIN;
  assign CarryOut = (A & B) | (CarryIN & halfSum);

endmodule

// File: rtl/serial_addition.sv
// Bit-serial unsigned adder: {CarryOUT, Y} = A + B + CarryIN, one bit per clock,
// LSB first, with a start/busy/done handshake.
module serial_addition
  import bttn_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             CarryOUT
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  stateT state;
  stateT stateNext;

  logic [WIDTH-1:0] aShift;
  logic [WIDTH-1:0] bShift;
  logic [WIDTH-1:0] sumShift;
  logic [WIDTH-1:0] sumNext;
  logic             carry;
  logic [CW-1:0]    bitCnt;
  logic             lastBit;
  logic             sumBit;
  logic             carryBit;

  // The single adder cell is reused every RUN cycle on the operand LSBs.
  fulladdition uFullAdd (
    .A       (aShift[0]),
    .B       (bShift[0]),
    .CarryIN (carry),
    .Sum     (sumBit),
    .CarryOut(carryBit)
  );

  assign lastBit = (bitCnt == LAST_BIT);
  // Result fills from the top, so after WIDTH shifts bit 0 sits at the LSB.
  assign sumNext = {sumBit, sumShift[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: accept in IDLE, run WIDTH bits, one DONE cycle.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (lastBit) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath and registered handshake: load, shift/add, publish result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aShift   <= '0;
      bShift   <= '0;
      sumShift <= '0;
      carry    <= 1'b0;
      bitCnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Y        <= '0;
      CarryOUT <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aShift   <= A;
            bShift   <= B;
            sumShift <= '0;
            carry    <= CarryIN;
            bitCnt   <= '0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          aShift   <= {1'b0, aShift[WIDTH-1:1]};
          bShift   <= {1'b0, bShift[WIDTH-1:1]};
          sumShift <= sumNext;
          carry    <= carryBit;
          bitCnt   <= bitCnt + 1'b1;
          if (lastBit) begin
            Y        <= sumNext;
            CarryOUT <= carryBit;
            done     <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addition.sv
// Scoreboard bench for serial_addition at WIDTH=4 and WIDTH=8.
module tb_serial_addition;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start4, cin4, busy4, done4, co4;
  logic [3:0] a4, b4, y4;
  logic       start8, cin8, busy8, done8, co8;
  logic [7:0] a8, b8, y8;

  serial_addition #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .CarryIN(cin4),
    .busy(busy4), .done(done4), .Y(y4), .CarryOUT(co4)
  );

  serial_addition #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .CarryIN(cin8),
    .busy(busy8), .done(done8), .Y(y8), .CarryOUT(co8)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [16:0] q4[$];
  logic [16:0] q8[$];
  logic [4:0]  last4 = '0;
  logic [8:0]  last8 = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Edge counter for latency and throughput measurement.
  always @(posedge clk) cyc++;

  // Push the exact sum whenever the next edge will accept a start.
  always @(negedge clk) begin
    if (rst_n && start4 && !busy4) q4.push_back(17'(a4) + 17'(b4) + 17'(cin4));
    if (rst_n && start8 && !busy8) q8.push_back(17'(a8) + 17'(b8) + 17'(cin8));
  end

  // Compare results on done and check outputs hold between done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      last4 = '0;
      last8 = '0;
    end else begin
      if (done4) begin
        if (q4.size() == 0) chk("sb4_empty", 32'd1, 32'd0);
        else chk("sb4", 32'({co4, y4}), 32'(q4.pop_front()));
        last4 = {co4, y4};
      end else begin
        chk("hold4", 32'({co4, y4}), 32'(last4));
      end
      if (done8) begin
        if (q8.size() == 0) chk("sb8_empty", 32'd1, 32'd0);
        else chk("sb8", 32'({co8, y8}), 32'(q8.pop_front()));
        last8 = {co8, y8};
      end else begin
        chk("hold8", 32'({co8, y8}), 32'(last8));
      end
    end
  end

  task automatic waitIdle4();
    @(posedge clk); #1;
    for (int t = 0; busy4 && t < 50; t++) begin @(posedge clk); #1; end
    if (busy4) chk("idle4_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle8();
    @(posedge clk); #1;
    for (int t = 0; busy8 && t < 50; t++) begin @(posedge clk); #1; end
    if (busy8) chk("idle8_timeout", 32'd0, 32'd1);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
    waitIdle4();
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int t = 0; !done4 && t < 50; t++) @(negedge clk);
    if (!done4) chk("done4_timeout", 32'd0, 32'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    waitIdle8();
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int t = 0; !done8 && t < 50; t++) @(negedge clk);
    if (!done8) chk("done8_timeout", 32'd0, 32'd1);
  endtask

  // Hard stop in case something never terminates.
  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int accCyc, doneCyc, busyCnt, doneCnt;
    int dq[$];
    logic prevDone;

    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_y4", 32'({co4, y4}), 32'd0);
    chk("rst_y8", 32'({busy8, done8, co8, y8}), 32'd0);

    // 3 + 4: latency, busy length and single-cycle done.
    waitIdle4();
    a4 = 4'd3; b4 = 4'd4; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    accCyc = cyc;
    busyCnt = 0; doneCnt = 0; doneCyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy4) break;
      busyCnt++;
      if (done4) begin doneCnt++; doneCyc = cyc; end
    end
    chk("lat4", 32'(doneCyc - accCyc), 32'd4);
    chk("busy_len4", 32'(busyCnt), 32'd5);
    chk("done_width4", 32'(doneCnt), 32'd1);
    chk("y_3p4", 32'({co4, y4}), 32'd7);

    // Overflow cases.
    op4(4'd15, 4'd1, 1'b0);
    chk("y_15p1", 32'({co4, y4}), 32'h10);
    op4(4'd9, 4'd7, 1'b1);
    chk("y_9p7p1", 32'({co4, y4}), 32'h11);

    // Start held high: one op per 6 cycles, operand changes mid-run ignored.
    waitIdle4();
    a4 = 4'd5; b4 = 4'd2; cin4 = 1'b0; start4 = 1'b1;
    prevDone = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done4) begin
        dq.push_back(cyc);
        chk("held_pulse", 32'(prevDone), 32'd0);
        chk("held_y", 32'({co4, y4}), 32'd7);
        a4 = 4'd5; b4 = 4'd2;
      end else if (busy4) begin
        a4 = 4'd9; b4 = 4'd6;
      end
      prevDone = done4;
    end
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("held_count", 32'(dq.size() >= 3), 32'd1);
    for (int i = 1; i < dq.size(); i++) chk("held_period", 32'(dq[i] - dq[i-1]), 32'd6);
    waitIdle4();
    a4 = 4'd5; b4 = 4'd2;

    // Reset during the second RUN cycle discards the run.
    waitIdle4();
    a4 = 4'd6; b4 = 4'd6; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q4.delete();
    q8.delete();
    @(negedge clk);
    chk("mid_rst4", 32'({busy4, done4, co4, y4}), 32'd0);
    op4(4'd1, 4'd1, 1'b0);
    chk("y_1p1", 32'({co4, y4}), 32'd2);

    // Eight-bit overflow and latency.
    waitIdle8();
    a8 = 8'd200; b8 = 8'd100; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    accCyc = cyc;
    for (int t = 0; !done8 && t < 50; t++) @(negedge clk);
    chk("lat8", 32'(cyc - accCyc), 32'd8);
    chk("y_200p100", 32'({co8, y8}), 32'h12C);

    // Random regression on both widths concurrently.
    fork
      begin
        for (int i = 0; i < 500; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          op4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
      end
      begin
        for (int i = 0; i < 500; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
      end
    join
    waitIdle4();
    waitIdle8();
    repeat (2) @(negedge clk);
    chk("sb4_left", 32'(q4.size()), 32'd0);
    chk("sb8_left", 32'(q8.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
